// File: rtl/k_and_s_memory.sv
// ---------------------------------------------------------------------------
// k_and_s_memory
//
// 32x16 word memory for the K&S processor datapath, plus a streaming
// program-loader port. After reset (or a load_start pulse) the block holds
// the processor and fills memory from word 0 upward. It releases the
// processor once the loader flags its last word or memory is full.
//
// Optional feature (macro K_AND_S_MEM_WP_EN):
//   When defined, processor writes in RUN to addresses below load_count are
//   dropped, and the sticky wp_violation flag is raised. When undefined, all
//   RUN writes are performed and wp_violation is tied to 0.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   ram_addr         processor word address (read and write)
//   ram_write_enable processor write strobe (RUN only)
//   data_out         processor write data
//   data_in          registered read data, 1-cycle latency, read-first
//   cpu_hold         high while loading
//   load_start       one-cycle pulse: restart loading from word 0
//   load_valid       loader word valid
//   load_ready       block accepts a loader word (LOAD only)
//   load_data        loader word
//   load_last        marks the final loader word
//   load_count       number of words loaded, 0..DEPTH, saturating
//   wp_violation     sticky protected-write flag
// ---------------------------------------------------------------------------
module k_and_s_memory #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_write_enable,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic              cpu_hold,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [ADDR_W:0]   load_count,
  output logic              wp_violation
);

  localparam int COUNT_W = ADDR_W + 1;
  localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0]   data_in_q;

  // Count a word accepted in the load_start cycle lands on: a restart
  // rebases the write pointer to 0 in that same cycle.
  logic [COUNT_W-1:0]  load_base;
  logic                load_accept;
  logic                load_done;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                run_wr_blocked;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  assign load_base   = load_start ? '0 : count_q;
  assign load_accept = (state_q == S_LOAD) && load_valid && (load_base != FULL);
  assign load_done   = load_accept && (load_last || (load_base + COUNT_W'(1) == FULL));

`ifdef K_AND_S_MEM_WP_EN
  logic wp_q, wp_d;

  // Words already delivered by the loader are read-only for the processor.
  assign run_wr_blocked = ({1'b0, ram_addr} < count_q);

  always_comb begin
    wp_d = wp_q;
    if ((state_q == S_RUN) && ram_write_enable && run_wr_blocked) begin
      wp_d = 1'b1;
    end
    // A restart clears the flag, taking priority over a same-cycle violation.
    if (load_start) begin
      wp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
    end
  end

  assign wp_violation = wp_q;
`else
  assign run_wr_blocked = 1'b0;
  assign wp_violation   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (load_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    cpu_hold   = 1'b1;
    load_ready = 1'b1;
    if (state_q == S_RUN) begin
      cpu_hold   = 1'b0;
      load_ready = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Load counter and the single memory write port, shared between the
  // loader (LOAD) and the processor (RUN).
  // -------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = ram_addr;
    wr_data = data_out;
    if (state_q == S_LOAD) begin
      count_d = load_base;
      if (load_accept) begin
        wr_en   = 1'b1;
        wr_addr = load_base[ADDR_W-1:0];
        wr_data = load_data;
        count_d = load_base + COUNT_W'(1);
      end
    end else begin
      // The processor write in a load_start cycle is still performed.
      if (ram_write_enable && !run_wr_blocked) begin
        wr_en = 1'b1;
      end
      if (load_start) begin
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      data_in_q <= '0;
    end else begin
      count_q   <= count_d;
      // Non-blocking read alongside the write below gives read-first.
      data_in_q <= mem[ram_addr];
    end
  end

  // Memory array: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign data_in    = data_in_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_k_and_s_memory.sv
module tb_k_and_s_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ram_addr;
  logic        ram_write_enable;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        cpu_hold;
  logic        load_start;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic [5:0]  load_count;
  logic        wp_violation;

  int checks = 0;
  int errors = 0;

`ifdef K_AND_S_MEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  k_and_s_memory dut (
    .clk              (clk),
    .rst              (rst),
    .ram_addr         (ram_addr),
    .ram_write_enable (ram_write_enable),
    .data_out         (data_out),
    .data_in          (data_in),
    .cpu_hold         (cpu_hold),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .load_last        (load_last),
    .load_count       (load_count),
    .wp_violation     (wp_violation)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [15:0] exp);
    ram_addr = a;
    tick();
    check(tag, 32'(data_in), 32'(exp));
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [15:0] d);
    ram_addr         = a;
    data_out         = d;
    ram_write_enable = 1'b1;
    tick();
    ram_write_enable = 1'b0;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ram_addr = '0; ram_write_enable = 1'b0; data_out = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_data_in",  32'(data_in), 32'h0);
    check("rst_hold",     32'(cpu_hold), 32'h1);
    check("rst_ready",    32'(load_ready), 32'h1);
    check("rst_count",    32'(load_count), 32'h0);
    check("rst_wp",       32'(wp_violation), 32'h0);
    rst = 1'b0;
    tick();

    // Three-word load terminated by load_last
    load_word(16'h8101, 1'b0);
    check("ld3_count1", 32'(load_count), 32'd1);
    check("ld3_hold1",  32'(cpu_hold), 32'h1);
    load_word(16'hA115, 1'b0);
    load_word(16'hFFFF, 1'b1);
    check("ld3_count3", 32'(load_count), 32'd3);
    check("ld3_hold",   32'(cpu_hold), 32'h0);
    check("ld3_ready",  32'(load_ready), 32'h0);
    read_check("ld3_rd0", 5'd0, 16'h8101);
    read_check("ld3_rd1", 5'd1, 16'hA115);
    read_check("ld3_rd2", 5'd2, 16'hFFFF);

    // Protected write to address 1 (load_count = 3), then unprotected addr 10
    cpu_write(5'd1, 16'hBEEF);
    check("wp_rd_first", 32'(data_in), 32'hA115);
    check("wp_flag",     32'(wp_violation), WP ? 32'h1 : 32'h0);
    read_check("wp_addr1", 5'd1, WP ? 16'hA115 : 16'hBEEF);
    cpu_write(5'd10, 16'h0A0A);
    read_check("wp_addr10", 5'd10, 16'h0A0A);

    // load_start from RUN; memory retained, next word lands at address 0
    pulse_load_start();
    check("ls_hold",  32'(cpu_hold), 32'h1);
    check("ls_count", 32'(load_count), 32'h0);
    check("ls_ready", 32'(load_ready), 32'h1);
    check("ls_wp",    32'(wp_violation), 32'h0);
    load_word(16'h5555, 1'b1);
    check("ls_count1", 32'(load_count), 32'd1);
    check("ls_run",    32'(cpu_hold), 32'h0);
    read_check("ls_rd0",    5'd0, 16'h5555);
    read_check("ls_keep1",  5'd1, WP ? 16'hA115 : 16'hBEEF);

    // Full 32-word load without load_last
    pulse_load_start();
    for (int i = 0; i < 31; i++) load_word(16'h1000 + 16'(i), 1'b0);
    check("full_count31", 32'(load_count), 32'd31);
    check("full_hold31",  32'(cpu_hold), 32'h1);
    load_word(16'h101F, 1'b0);
    check("full_count32", 32'(load_count), 32'd32);
    check("full_ready",   32'(load_ready), 32'h0);
    check("full_hold",    32'(cpu_hold), 32'h0);
    load_valid = 1'b1; load_data = 16'hDEAD;
    tick(); tick();
    load_valid = 1'b0;
    check("full_sat", 32'(load_count), 32'd32);
    read_check("full_rd0",  5'd0,  16'h1000);
    read_check("full_rd31", 5'd31, 16'h101F);

    // Read-during-write at address 20 (every address protected with WP)
    cpu_write(5'd20, 16'h1234);
    check("rdw_old", 32'(data_in), 32'h1014);
    read_check("rdw_new", 5'd20, WP ? 16'h1014 : 16'h1234);

    // Reset after 2 of 5 loader words
    pulse_load_start();
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(load_count), 32'h0);
    check("mid_rst_hold",  32'(cpu_hold), 32'h1);
    tick();
    rst = 1'b0;
    read_check("mid_rst_rd0", 5'd0, 16'hAAAA);
    read_check("mid_rst_rd1", 5'd1, 16'hBBBB);

    // load_start in LOAD with a same-cycle accepted word
    load_word(16'hCCCC, 1'b0);
    load_start = 1'b1;
    load_word(16'hDDDD, 1'b0);
    load_start = 1'b0;
    check("ls_load_count", 32'(load_count), 32'd1);
    load_word(16'hEEEE, 1'b1);
    check("ls_load_count2", 32'(load_count), 32'd2);
    check("ls_load_run",    32'(cpu_hold), 32'h0);
    read_check("ls_load_rd0", 5'd0, 16'hDDDD);
    read_check("ls_load_rd1", 5'd1, 16'hEEEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k_and_s_memory.md
# k_and_s_memory

Synchronous 32×16 word memory that responds to the K&S processor datapath's memory port: `ram_addr`, write data, and a write strobe in; read data back on `data_in`. It also owns a streaming program-loader port. While loading, the block holds the processor and fills memory from word 0 upward. It then releases the processor to run. It sits between the K&S processor top and the testbench or host loader.

## Interface
Parameters:
- `ADDR_W`, 5: memory address width.
- `DATA_W`, 16: word width.
- `DEPTH`, 32: number of words; must equal 2**ADDR_W.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `ram_addr`  in  ADDR_W  processor word address (read and write).
- `ram_write_enable`  in  1  processor write strobe.
- `data_out`  in  DATA_W  processor write data.
- `data_in`  out  DATA_W  registered read data to the processor.
- `cpu_hold`  out  1  high while loading; the processor must not advance.
- `load_start`  in  1  one-cycle pulse; restarts program loading.
- `load_valid`  in  1  loader word valid.
- `load_ready`  out  1  block accepts a loader word.
- `load_data`  in  DATA_W  loader word.
- `load_last`  in  1  marks the final loader word.
- `load_count`  out  ADDR_W+1  number of words loaded, 0..DEPTH.
- `wp_violation`  out  1  sticky protected-write flag; present only when the macro is enabled, otherwise tied 0.

## Operation
- FSM has two states, LOAD and RUN. Reset enters LOAD.
- **LOAD state:**
  - `cpu_hold`=1 and `load_ready`=1.
  - Each cycle with `load_valid`&`load_ready` writes `load_data` to `mem[load_count]` and increments `load_count`.
  - LOAD→RUN after the accepted word has `load_last`=1, or after `load_count` reaches DEPTH, whichever comes first.
  - `ram_write_enable` is ignored in LOAD.
- **RUN state:**
  - `cpu_hold`=0 and `load_ready`=0; `load_valid` is ignored.
  - `ram_write_enable`=1 writes `data_out` to `mem[ram_addr]`.
  - `load_start`=1 forces a return to LOAD: `load_count` clears to 0, and memory contents are retained until overwritten.
- `load_start` asserted in LOAD also clears `load_count` to 0. A word accepted in that same cycle is written to address 0, and the count becomes 1.
- The read port is always active in both states: `data_in` <= `mem[ram_addr]` at every rising edge.
- Memory contents are not reset.
- `load_count` saturates at DEPTH and never wraps.

## Timing
- Reset values:
  - `data_in`=0, `cpu_hold`=1, `load_ready`=1, `load_count`=0, `wp_violation`=0, state LOAD.
- Reset mid-load: the state is LOAD, `load_count` is 0, and words already written remain in memory.
- Read latency is 1 cycle. An address presented in cycle N produces data on `data_in` in cycle N+1.
- Read-during-write to the same address is read-first: `data_in` returns the old word. The new word is visible on the following read.
- Load handshake:
  - A word is accepted on a rising edge where `load_valid`&`load_ready`.
  - `load_ready` drops in the cycle after the last or DEPTH-th word is accepted.
  - `cpu_hold` falls in that same cycle.
- `load_start` takes effect at the next edge: `cpu_hold`=1 from the following cycle. A processor write in the same cycle as `load_start` is still performed.

## Configuration
- Macro: `K_AND_S_MEM_WP_EN`.
- Defined: processor writes in RUN to addresses < `load_count` are dropped, and `wp_violation` sets and stays set until `rst` or `load_start`. Reads are unaffected.
- Undefined: all RUN writes are performed and `wp_violation` is constant 0.

## Test plan
- Reset, then load 3 words 0x8101, 0xA115, 0xFFFF with `load_last` on the third → `load_count`=3, `cpu_hold` falls the cycle after the third accept, and addresses 0..2 read back the words with 1-cycle latency.
- Load 32 words without `load_last` → after the 32nd accept, `load_count`=32, `load_ready`=0, `cpu_hold`=0; further `load_valid` has no effect.
- In RUN, write 0x1234 to address 20 and read address 20 in the same cycle → `data_in`=old value; the next read gives 0x1234.
- Pulse `rst` after 2 of 5 loader words → `load_count`=0, `cpu_hold`=1, and addresses 0..1 keep the loaded words.
- With `K_AND_S_MEM_WP_EN` and `load_count`=3, write 0xBEEF to address 1 in RUN → memory unchanged and `wp_violation`=1; a write to address 10 succeeds. Without the macro, both writes succeed and `wp_violation`=0.
- Pulse `load_start` in RUN → `cpu_hold`=1 and `load_count`=0 next cycle; the next loaded word lands at address 0.
